// File: rtl/dsp_mult_arbiter_pkg.sv
// Shared definitions for the DSP multiplier arbiter: operand widths, the
// ownership tag carried alongside each in-flight product, and the constant
// feedback code that keeps the DSP tile in plain multiply mode.
package dsp_mult_arb_pkg;

  // Operand and product widths of the qlf_k6n10f DSP tile in multiply mode.
  localparam int A_W = 20;
  localparam int B_W = 18;
  localparam int Z_W = 38;

  // Tag ID field is sized for the largest supported requester count (8).
  // Narrower configurations zero-extend into it.
  localparam int TAG_ID_W = 3;

  // Feedback code for "multiply only, no accumulate".
  localparam logic [2:0] FEEDBACK_MULT = 3'h0;

  // Ownership tag that travels beside each product through the DSP latency.
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  // Wrap an index that may exceed the requester count by less than one lap.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/dsp_mult_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter. The search starts one position after
// the last granted index and wraps; the first asserted request wins.
module rr_arbiter
  import dsp_mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_valid
);

  // Candidate gi is the requester that sits gi+1 places after last_grant.
  logic [ID_W-1:0]    cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_req;

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign cand_idx[gi] = ID_W'(rr_wrap(int'(last_grant) + gi + 1, NUM_REQ));
    assign cand_req[gi] = req[cand_idx[gi]];
  end

  // Priority pick over the rotated candidates: nearest offset wins, so scan
  // from the far end and let closer candidates overwrite.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        grant_idx   = cand_idx[k];
        grant_valid = 1'b1;
      end
    end
    grant[grant_idx] = grant_valid;
  end

endmodule

// File: rtl/dsp_mult_arbiter.sv
// Shares one multiply-only DSP tile among NUM_REQ requesters. One operand
// pair is accepted per cycle by round-robin, registered onto the DSP input
// ports, and its owner is carried through a tag pipeline matching the DSP
// latency so each product leaves on the result bus with its requester ID.
module dsp_mult_arbiter
  import dsp_mult_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int MULT_LATENCY = 0
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [NUM_REQ*A_W-1:0] req_a_i,
  input  logic [NUM_REQ*B_W-1:0] req_b_i,
  input  logic [NUM_REQ-1:0]     req_unsigned_a_i,
  input  logic [NUM_REQ-1:0]     req_unsigned_b_i,
  output logic [A_W-1:0]         dsp_a_o,
  output logic [B_W-1:0]         dsp_b_o,
  output logic                   dsp_unsigned_a_o,
  output logic                   dsp_unsigned_b_o,
  output logic [2:0]             dsp_feedback_o,
  input  logic [Z_W-1:0]         dsp_z_i,
  output logic                   res_valid_o,
  output logic [ID_W-1:0]        res_id_o,
  output logic [Z_W-1:0]         res_z_o,
  output logic                   busy_o
);

  // One tag stage for the operand register plus one per extra DSP stage.
  localparam int DEPTH = MULT_LATENCY + 1;

  // Unpacked per-requester operand lanes.
  logic [A_W-1:0] a_lane [NUM_REQ];
  logic [B_W-1:0] b_lane [NUM_REQ];

  // Arbiter results.
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_valid;
  logic               accept;

  // Operand registers feeding the DSP and the round-robin pointer.
  logic [A_W-1:0]  dsp_a_reg, dsp_a_next;
  logic [B_W-1:0]  dsp_b_reg, dsp_b_next;
  logic            dsp_ua_reg, dsp_ua_next;
  logic            dsp_ub_reg, dsp_ub_next;
  logic [ID_W-1:0] last_grant_reg, last_grant_next;

  // Ownership tag pipeline.
  tag_t             tag_next;
  tag_t             tag_reg [DEPTH];
  logic [DEPTH-1:0] tag_valid;

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign a_lane[gi] = req_a_i[gi*A_W +: A_W];
    assign b_lane[gi] = req_b_i[gi*B_W +: B_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req         (req_valid_i),
    .last_grant  (last_grant_reg),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Nobody is granted while reset is held, so no handshake can slip in.
  assign req_ready_o = reset_i ? '0 : grant;
  assign accept      = grant_valid & ~reset_i;

  // Select the winner's operands, flags and index; hold everything otherwise.
  always_comb begin
    dsp_a_next      = dsp_a_reg;
    dsp_b_next      = dsp_b_reg;
    dsp_ua_next     = dsp_ua_reg;
    dsp_ub_next     = dsp_ub_reg;
    last_grant_next = last_grant_reg;
    if (accept) begin
      dsp_a_next      = a_lane[grant_idx];
      dsp_b_next      = b_lane[grant_idx];
      dsp_ua_next     = req_unsigned_a_i[grant_idx];
      dsp_ub_next     = req_unsigned_b_i[grant_idx];
      last_grant_next = grant_idx;
    end
  end

  // Operand and pointer registers; the pointer resets to the last index so
  // requester 0 has first priority.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      dsp_a_reg      <= '0;
      dsp_b_reg      <= '0;
      dsp_ua_reg     <= 1'b0;
      dsp_ub_reg     <= 1'b0;
      last_grant_reg <= ID_W'(NUM_REQ - 1);
    end else begin
      dsp_a_reg      <= dsp_a_next;
      dsp_b_reg      <= dsp_b_next;
      dsp_ua_reg     <= dsp_ua_next;
      dsp_ub_reg     <= dsp_ub_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // A new tag enters the pipeline on every handshake; empty otherwise.
  always_comb begin
    tag_next       = '0;
    tag_next.valid = accept;
    tag_next.id    = TAG_ID_W'(grant_idx);
  end

  // Shift tags in lockstep with the DSP so the last stage lines up with the
  // product on dsp_z_i. Reset discards everything in flight.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int s = 0; s < DEPTH; s++) begin
        tag_reg[s] <= '0;
      end
    end else begin
      tag_reg[0] <= tag_next;
      for (int s = 1; s < DEPTH; s++) begin
        tag_reg[s] <= tag_reg[s-1];
      end
    end
  end

  for (gi = 0; gi < DEPTH; gi++) begin : g_busy
    assign tag_valid[gi] = tag_reg[gi].valid;
  end

  assign dsp_a_o          = dsp_a_reg;
  assign dsp_b_o          = dsp_b_reg;
  assign dsp_unsigned_a_o = dsp_ua_reg;
  assign dsp_unsigned_b_o = dsp_ub_reg;
  assign dsp_feedback_o   = FEEDBACK_MULT;

  assign res_valid_o = tag_reg[DEPTH-1].valid;
  assign res_id_o    = ID_W'(tag_reg[DEPTH-1].id);
  assign res_z_o     = dsp_z_i;
  assign busy_o      = |tag_valid;

endmodule

// File: tb/tb_dsp_mult_arbiter.sv
// Bench for dsp_mult_arbiter: two instances (DSP latency 0 and 1) share the
// same requester stimulus, each with its own behavioural DSP model.
`timescale 1ns/1ps
module tb_dsp_mult_arbiter;
  import dsp_mult_arb_pkg::*;

  localparam int N    = 4;
  localparam int ID_W = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]     req_valid, req_ua, req_ub;
  logic [A_W-1:0]   a_v [N];
  logic [B_W-1:0]   b_v [N];
  logic [N*A_W-1:0] req_a;
  logic [N*B_W-1:0] req_b;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*A_W +: A_W] = a_v[i];
      req_b[i*B_W +: B_W] = b_v[i];
    end
  end

  // DUT 0 (latency 0) and DUT 1 (latency 1) outputs
  logic [N-1:0]    ready0, ready1;
  logic [A_W-1:0]  dsp_a0, dsp_a1;
  logic [B_W-1:0]  dsp_b0, dsp_b1;
  logic            dua0, dub0, dua1, dub1;
  logic [2:0]      fb0, fb1;
  logic [Z_W-1:0]  z0, z1, rz0, rz1;
  logic            rv0, rv1, busy0, busy1;
  logic [ID_W-1:0] rid0, rid1;

  function automatic logic [Z_W-1:0] dsp_mul(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                             input logic ua, input logic ub);
    logic signed [A_W:0]       sa;
    logic signed [B_W:0]       sb;
    logic signed [A_W+B_W+1:0] p;
    sa = ua ? $signed({1'b0, a}) : $signed({a[A_W-1], a});
    sb = ub ? $signed({1'b0, b}) : $signed({b[B_W-1], b});
    p  = sa * sb;
    return p[Z_W-1:0];
  endfunction

  // DSP models: combinational for latency 0, input-registered for latency 1
  assign z0 = dsp_mul(dsp_a0, dsp_b0, dua0, dub0);
  always @(posedge clk or posedge rst) begin
    if (rst) z1 <= '0;
    else     z1 <= dsp_mul(dsp_a1, dsp_b1, dua1, dub1);
  end

  dsp_mult_arbiter #(.NUM_REQ(N), .ID_W(ID_W), .MULT_LATENCY(0)) dut0 (
    .clock_i(clk), .reset_i(rst), .req_valid_i(req_valid), .req_ready_o(ready0),
    .req_a_i(req_a), .req_b_i(req_b), .req_unsigned_a_i(req_ua), .req_unsigned_b_i(req_ub),
    .dsp_a_o(dsp_a0), .dsp_b_o(dsp_b0), .dsp_unsigned_a_o(dua0), .dsp_unsigned_b_o(dub0),
    .dsp_feedback_o(fb0), .dsp_z_i(z0), .res_valid_o(rv0), .res_id_o(rid0),
    .res_z_o(rz0), .busy_o(busy0)
  );

  dsp_mult_arbiter #(.NUM_REQ(N), .ID_W(ID_W), .MULT_LATENCY(1)) dut1 (
    .clock_i(clk), .reset_i(rst), .req_valid_i(req_valid), .req_ready_o(ready1),
    .req_a_i(req_a), .req_b_i(req_b), .req_unsigned_a_i(req_ua), .req_unsigned_b_i(req_ub),
    .dsp_a_o(dsp_a1), .dsp_b_o(dsp_b1), .dsp_unsigned_a_o(dua1), .dsp_unsigned_b_o(dub1),
    .dsp_feedback_o(fb1), .dsp_z_i(z1), .res_valid_o(rv1), .res_id_o(rid1),
    .res_z_o(rz1), .busy_o(busy1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Scoreboard: push the expected product at each handshake, pop on strobe
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [Z_W-1:0]  z;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   acc0 = 0, acc1 = 0, got0 = 0, got1 = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      acc0 -= q0.size();
      acc1 -= q1.size();
      q0.delete();
      q1.delete();
    end else begin
      if (rv0) begin
        got0++;
        if (q0.size() == 0) check("dut0 strobe with empty scoreboard", rv0, 0);
        else begin
          e = q0.pop_front();
          $display("dut0 result id=%0d z=0x%0h", rid0, rz0);
          check("dut0 res_id", rid0, e.id);
          check("dut0 res_z", rz0, e.z);
        end
      end
      if (rv1) begin
        got1++;
        if (q1.size() == 0) check("dut1 strobe with empty scoreboard", rv1, 0);
        else begin
          e = q1.pop_front();
          $display("dut1 result id=%0d z=0x%0h", rid1, rz1);
          check("dut1 res_id", rid1, e.id);
          check("dut1 res_z", rz1, e.z);
        end
      end
      for (int i = 0; i < N; i++) begin
        e.id = ID_W'(i);
        e.z  = dsp_mul(a_v[i], b_v[i], req_ua[i], req_ub[i]);
        if (req_valid[i] && ready0[i]) begin q0.push_back(e); acc0++; end
        if (req_valid[i] && ready1[i]) begin q1.push_back(e); acc1++; end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      a_v[i] = A_W'($urandom);
      b_v[i] = B_W'($urandom);
    end
    req_ua = N'($urandom);
    req_ub = N'($urandom);
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] ready;
  } vec_t;

  vec_t tbl [20];

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] exp_ready;
    int           exp_last;
    int           win;

    // Grant table from reset (pointer starts at 3)
    tbl[ 0] = '{4'b0000, 4'b0000};
    tbl[ 1] = '{4'b1111, 4'b0001};
    tbl[ 2] = '{4'b1111, 4'b0010};
    tbl[ 3] = '{4'b1111, 4'b0100};
    tbl[ 4] = '{4'b1111, 4'b1000};
    tbl[ 5] = '{4'b1111, 4'b0001};
    tbl[ 6] = '{4'b1111, 4'b0010};
    tbl[ 7] = '{4'b1111, 4'b0100};
    tbl[ 8] = '{4'b1111, 4'b1000};
    tbl[ 9] = '{4'b0100, 4'b0100};
    tbl[10] = '{4'b0100, 4'b0100};
    tbl[11] = '{4'b1001, 4'b1000};
    tbl[12] = '{4'b1001, 4'b0001};
    tbl[13] = '{4'b0000, 4'b0000};
    tbl[14] = '{4'b1010, 4'b0010};
    tbl[15] = '{4'b0110, 4'b0100};
    tbl[16] = '{4'b0011, 4'b0001};
    tbl[17] = '{4'b1010, 4'b0010};
    tbl[18] = '{4'b0100, 4'b0100};
    tbl[19] = '{4'b1001, 4'b1000};

    // Reset state, with every requester asserting valid
    rst       = 1'b1;
    req_valid = '1;
    req_ua    = '0;
    req_ub    = '0;
    for (int i = 0; i < N; i++) begin a_v[i] = '1; b_v[i] = '1; end
    repeat (2) @(posedge clk);
    sample();
    check("reset ready0", ready0, 0);
    check("reset ready1", ready1, 0);
    check("reset dsp_a0", dsp_a0, 0);
    check("reset dsp_b0", dsp_b0, 0);
    check("reset flags0", {dua0, dub0}, 0);
    check("reset feedback0", fb0, 0);
    check("reset feedback1", fb1, 0);
    check("reset res_valid0", rv0, 0);
    check("reset res_id0", rid0, 0);
    check("reset res_z0", rz0, 0);
    check("reset busy", {busy0, busy1}, 0);
    cycle();
    rst       = 1'b0;
    req_valid = '0;

    // Table-driven grant order
    for (int k = 0; k < 20; k++) begin
      cycle();
      req_valid = tbl[k].valid;
      rand_ops();
      sample();
      $display("table[%0d] valid=%b ready0=%b ready1=%b", k, req_valid, ready0, ready1);
      check($sformatf("table[%0d] ready0", k), ready0, tbl[k].ready);
      check($sformatf("table[%0d] ready1", k), ready1, tbl[k].ready);
    end
    cycle();
    req_valid = '0;
    repeat (3) cycle();

    // Single requester: 2 presents -3 * 7 signed
    req_valid = 4'b0100;
    a_v[2] = 20'hFFFFD; b_v[2] = 18'd7; req_ua[2] = 1'b0; req_ub[2] = 1'b0;
    sample();
    check("single ready0", ready0, 4'b0100);
    cycle();
    req_valid = '0;
    sample();
    $display("single: rv0=%0d id0=%0d z0=0x%0h busy1=%0d", rv0, rid0, rz0, busy1);
    check("single rv0 at N+1", rv0, 1);
    check("single id0", rid0, 2);
    check("single z0", rz0, 38'h3FFFFFFFEB);
    check("single busy0 at N+1", busy0, 1);
    check("single rv1 at N+1", rv1, 0);
    check("single busy1 at N+1", busy1, 1);
    cycle();
    sample();
    check("single rv0 at N+2", rv0, 0);
    check("single busy0 at N+2", busy0, 0);
    check("single rv1 at N+2", rv1, 1);
    check("single id1", rid1, 2);
    check("single z1", rz1, 38'h3FFFFFFFEB);
    check("single busy1 at N+2", busy1, 1);
    cycle();
    sample();
    check("single rv1 at N+3", rv1, 0);
    check("single busy1 at N+3", busy1, 0);

    // Unsigned extremes then the same bits signed, back-to-back on requester 1
    cycle();
    req_valid = 4'b0010;
    a_v[1] = 20'hFFFFF; b_v[1] = 18'h3FFFF; req_ua[1] = 1'b1; req_ub[1] = 1'b1;
    sample();
    check("uns ready0", ready0, 4'b0010);
    cycle();
    req_ua[1] = 1'b0; req_ub[1] = 1'b0;
    sample();
    check("uns back-to-back ready0", ready0, 4'b0010);
    check("uns z0", rz0, 38'h3FFFEC0001);
    check("uns id0", rid0, 1);
    cycle();
    req_valid = '0;
    sample();
    check("signed z0", rz0, 38'h1);
    check("signed rv0", rv0, 1);
    check("uns z1", rz1, 38'h3FFFEC0001);
    check("uns rv1", rv1, 1);
    cycle();
    sample();
    check("signed z1", rz1, 38'h1);
    check("signed rv1", rv1, 1);
    check("uns tail rv0", rv0, 0);

    // Reset with two products in flight on the latency-1 instance
    cycle();
    req_valid = 4'b0011;
    rand_ops();
    sample();
    check("rst-seq ready0 first", ready0, 4'b0001);
    cycle();
    sample();
    check("rst-seq ready0 second", ready0, 4'b0010);
    check("rst-seq busy1", busy1, 1);
    cycle();
    rst       = 1'b1;
    req_valid = '1;
    sample();
    check("mid-reset ready", {ready0, ready1}, 0);
    check("mid-reset res_valid", {rv0, rv1}, 0);
    check("mid-reset busy", {busy0, busy1}, 0);
    check("mid-reset dsp_a0", dsp_a0, 0);
    check("mid-reset dsp_b1", dsp_b1, 0);
    check("mid-reset flags", {dua0, dub0, dua1, dub1}, 0);
    check("mid-reset res_id1", rid1, 0);
    check("mid-reset res_z0", rz0, 0);
    check("mid-reset res_z1", rz1, 0);
    cycle();
    rst = 1'b0;
    sample();
    check("post-reset ready0", ready0, 4'b0001);
    check("post-reset ready1", ready1, 4'b0001);
    check("post-reset no stale strobe", {rv0, rv1}, 0);
    cycle();
    req_valid = '0;
    sample();
    check("post-reset dut1 no stale strobe", rv1, 0);
    repeat (3) cycle();

    // Random traffic against the round-robin model and the scoreboard
    rst = 1'b1;
    cycle();
    rst      = 1'b0;
    exp_last = N - 1;
    for (int c = 0; c < 10000; c++) begin
      cycle();
      req_valid = N'($urandom);
      rand_ops();
      sample();
      exp_ready = '0;
      win       = 0;
      for (int off = 1; off <= N; off++) begin
        int idx;
        idx = (exp_last + off) % N;
        if (req_valid[idx] && exp_ready == 0) begin
          exp_ready[idx] = 1'b1;
          win            = idx;
        end
      end
      check("rand ready0", ready0, exp_ready);
      check("rand ready1", ready1, exp_ready);
      if (exp_ready != 0) exp_last = win;
    end
    cycle();
    req_valid = '0;
    repeat (4) cycle();
    sample();
    check("drain q0 empty", q0.size(), 0);
    check("drain q1 empty", q1.size(), 0);
    check("dut0 results == accepts", got0, acc0);
    check("dut1 results == accepts", got1, acc1);
    check("drain busy", {busy0, busy1}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
